// File: rtl/cfg_loader_pkg.sv
// Shared types and helpers for the ioctl configuration loader.
// Session states, well-known ioctl indices and bank packing.
package cfg_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIP   = 2'd1,
    HDR   = 2'd2,
    OTHER = 2'd3
  } state_e;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_DIP = 8'd254;

  // Largest supported bank count; packing always works at this width.
  localparam int MAX_BANKS = 16;

  function automatic logic [MAX_BANKS*8-1:0] pack_banks(input logic [7:0] banks [MAX_BANKS]);
    logic [MAX_BANKS*8-1:0] flat;
    flat = '0;
    for (int k = 0; k < MAX_BANKS; k++) begin
      flat[8*k +: 8] = banks[k];
    end
    return flat;
  endfunction

endpackage

// File: rtl/ioctl_session_tracker.sv
// Follows ioctl download sessions: edge detection, session index latch,
// write qualification, byte counting and the end-of-session pulse.
module ioctl_session_tracker
  import cfg_loader_pkg::*;
#(
  parameter logic [7:0] DIP_INDEX = IDX_DIP,
  parameter logic [7:0] HDR_INDEX = 8'd1,
  parameter int         ADDR_W    = 25
) (
  input  logic            clk_49m,
  input  logic            reset,
  input  logic            ioctl_download,
  input  logic [7:0]      ioctl_index,
  input  logic            ioctl_wr,
  output state_e          state_o,
  output logic            start_o,
  output logic            accept_o,
  output logic            dl_done,
  output logic [7:0]      dl_index,
  output logic [ADDR_W:0] dl_bytes
);

  state_e            state_q, state_d;
  logic              prev_q;
  logic [7:0]        sess_idx_q, sess_idx_d;
  logic [7:0]        dl_index_q, dl_index_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   bytes_q, bytes_d;
  logic              start, fall, accept;

  assign start = ioctl_download & ~prev_q;
  assign fall  = ~ioctl_download & prev_q & (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    sess_idx_d = sess_idx_q;
    dl_index_d = dl_index_q;
    done_d     = 1'b0;
    bytes_d    = bytes_q;
    if (start) begin
      sess_idx_d = ioctl_index;
      bytes_d    = '0;
      if (ioctl_index == DIP_INDEX)      state_d = DIP;
      else if (ioctl_index == HDR_INDEX) state_d = HDR;
      else                               state_d = OTHER;
    end else if (fall) begin
      state_d    = IDLE;
      done_d     = 1'b1;
      dl_index_d = sess_idx_q;
    end
    // state_d/sess_idx_d already reflect a session starting this cycle,
    // so a write in the start cycle is judged against the new session.
    accept = ioctl_wr & ioctl_download & (state_d != IDLE) & (ioctl_index == sess_idx_d);
    if (accept && (bytes_d != '1)) bytes_d = bytes_d + 1'b1;
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      prev_q     <= 1'b1;
      sess_idx_q <= '0;
      dl_index_q <= '0;
      done_q     <= 1'b0;
      bytes_q    <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= ioctl_download;
      sess_idx_q <= sess_idx_d;
      dl_index_q <= dl_index_d;
      done_q     <= done_d;
      bytes_q    <= bytes_d;
    end
  end

  assign state_o  = start ? state_d : state_q;
  assign start_o  = start;
  assign accept_o = accept;
  assign dl_done  = done_q;
  assign dl_index = dl_index_q;
  assign dl_bytes = bytes_q;

endmodule

// File: rtl/ioctl_cfg_loader.sv
// Captures DIP banks and ROM header bytes from HPS ioctl downloads and
// reports session completion, byte count and DIP overflow to the core.
module ioctl_cfg_loader
  import cfg_loader_pkg::*;
#(
  parameter int                     NUM_BANKS   = 8,
  parameter int                     HDR_BYTES   = 1,
  parameter logic [7:0]             DIP_INDEX   = IDX_DIP,
  parameter logic [7:0]             HDR_INDEX   = 8'd1,
  parameter int                     ADDR_W      = 25,
  parameter logic [NUM_BANKS*8-1:0] DIP_DEFAULT = '0,
  parameter bit                     INVERT      = 1'b1
) (
  input  logic                   clk_49m,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic [7:0]             ioctl_index,
  input  logic                   ioctl_wr,
  input  logic [ADDR_W-1:0]      ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  output logic [NUM_BANKS*8-1:0] dip_sw,
  output logic [HDR_BYTES*8-1:0] hdr,
  output logic                   dip_valid,
  output logic                   hdr_valid,
  output logic                   dl_done,
  output logic [7:0]             dl_index,
  output logic [ADDR_W:0]        dl_bytes,
  output logic                   dip_overflow
);

  state_e st;
  logic   start, accept;

  ioctl_session_tracker #(
    .DIP_INDEX (DIP_INDEX),
    .HDR_INDEX (HDR_INDEX),
    .ADDR_W    (ADDR_W)
  ) u_tracker (
    .clk_49m        (clk_49m),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .state_o        (st),
    .start_o        (start),
    .accept_o       (accept),
    .dl_done        (dl_done),
    .dl_index       (dl_index),
    .dl_bytes       (dl_bytes)
  );

  logic [7:0]           bank_q [NUM_BANKS];
  logic [7:0]           bank_d [NUM_BANKS];
  logic [HDR_BYTES*8-1:0] hdr_q, hdr_d;
  logic [HDR_BYTES-1:0] mask_q, mask_d;
  logic                 dip_valid_q, dip_valid_d;
  logic                 hdr_valid_q, hdr_valid_d;
  logic                 ovf_q, ovf_d;

  always_comb begin
    bank_d      = bank_q;
    hdr_d       = hdr_q;
    mask_d      = mask_q;
    dip_valid_d = dip_valid_q;
    ovf_d       = ovf_q;
    // Header validity follows a complete mask by one cycle.
    hdr_valid_d = hdr_valid_q | (&mask_q);
    if (start && st == DIP) ovf_d = 1'b0;
    if (start && st == HDR) begin
      hdr_valid_d = 1'b0;
      mask_d      = '0;
    end
    if (accept && st == DIP) begin
      if (ioctl_addr < ADDR_W'(NUM_BANKS)) begin
        dip_valid_d = 1'b1;
        for (int k = 0; k < NUM_BANKS; k++) begin
          if (ioctl_addr == ADDR_W'(k)) bank_d[k] = ioctl_dout;
        end
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (accept && st == HDR) begin
      for (int k = 0; k < HDR_BYTES; k++) begin
        if (ioctl_addr == ADDR_W'(k)) begin
          hdr_d[8*k +: 8] = ioctl_dout;
          mask_d[k]       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_BANKS; k++) bank_q[k] <= DIP_DEFAULT[8*k +: 8];
      hdr_q       <= '0;
      mask_q      <= '0;
      dip_valid_q <= 1'b0;
      hdr_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      hdr_q       <= hdr_d;
      mask_q      <= mask_d;
      dip_valid_q <= dip_valid_d;
      hdr_valid_q <= hdr_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  logic [7:0]             scratch [MAX_BANKS];
  logic [MAX_BANKS*8-1:0] flat;
  logic [NUM_BANKS*8-1:0] storage;

  always_comb begin
    scratch = '{default: 8'h00};
    for (int k = 0; k < NUM_BANKS; k++) scratch[k] = bank_q[k];
  end

  assign flat    = pack_banks(scratch);
  assign storage = flat[NUM_BANKS*8-1:0];

  if (NUM_BANKS < MAX_BANKS) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^flat[MAX_BANKS*8-1:NUM_BANKS*8];
  end

  assign dip_sw       = INVERT ? ~storage : storage;
  assign hdr          = hdr_q;
  assign dip_valid    = dip_valid_q;
  assign hdr_valid    = hdr_valid_q;
  assign dip_overflow = ovf_q;

endmodule

// File: tb/tb_ioctl_cfg_loader.sv
// Directed bench for ioctl_cfg_loader: 8 banks, 2 header bytes, inverted DIPs.
module tb_ioctl_cfg_loader;

  localparam int ADDR_W = 25;

  logic              clk_49m = 1'b0;
  logic              reset;
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [63:0]       dip_sw;
  logic [15:0]       hdr;
  logic              dip_valid, hdr_valid, dl_done, dip_overflow;
  logic [7:0]        dl_index;
  logic [ADDR_W:0]   dl_bytes;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int done_ref;

  ioctl_cfg_loader #(
    .NUM_BANKS   (8),
    .HDR_BYTES   (2),
    .DIP_INDEX   (8'd254),
    .HDR_INDEX   (8'd1),
    .ADDR_W      (ADDR_W),
    .DIP_DEFAULT (64'h0),
    .INVERT      (1'b1)
  ) dut (
    .clk_49m        (clk_49m),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .dip_sw         (dip_sw),
    .hdr            (hdr),
    .dip_valid      (dip_valid),
    .hdr_valid      (hdr_valid),
    .dl_done        (dl_done),
    .dl_index       (dl_index),
    .dl_bytes       (dl_bytes),
    .dip_overflow   (dip_overflow)
  );

  // Clock and pulse counter (sampled on the inactive edge).
  always #5 clk_49m = ~clk_49m;
  always @(negedge clk_49m) if (dl_done === 1'b1) done_cnt++;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic [63:0]       exp_sw;
    logic              exp_ovf;
    logic [ADDR_W:0]   exp_bytes;
  } vec_t;

  vec_t vecs [5];

  task automatic tick(input int n);
    repeat (n) @(posedge clk_49m);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_sess(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick(1);
  endtask

  task automatic wr_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick(1);
    ioctl_wr   = 1'b0;
  endtask

  task automatic end_sess();
    ioctl_download = 1'b0;
    tick(2);
  endtask

  task automatic apply_vec(input int i);
    wr_byte(vecs[i].addr, vecs[i].data);
    check($sformatf("vec%0d dip_sw", i), dip_sw, vecs[i].exp_sw);
    check($sformatf("vec%0d overflow", i), 64'(dip_overflow), 64'(vecs[i].exp_ovf));
    check($sformatf("vec%0d dl_bytes", i), 64'(dl_bytes), 64'(vecs[i].exp_bytes));
  endtask

  initial begin
    vecs[0] = '{addr: 25'd0,     data: 8'h5A, exp_sw: 64'hFFFF_FFFF_FFFF_FFA5, exp_ovf: 1'b0, exp_bytes: 26'd1};
    vecs[1] = '{addr: 25'd1,     data: 8'h03, exp_sw: 64'hFFFF_FFFF_FFFF_FCA5, exp_ovf: 1'b0, exp_bytes: 26'd2};
    vecs[2] = '{addr: 25'd7,     data: 8'h80, exp_sw: 64'h7FFF_FFFF_FFFF_FCA5, exp_ovf: 1'b0, exp_bytes: 26'd1};
    vecs[3] = '{addr: 25'd8,     data: 8'hFF, exp_sw: 64'h7FFF_FFFF_FFFF_FCA5, exp_ovf: 1'b1, exp_bytes: 26'd2};
    vecs[4] = '{addr: 25'h100,   data: 8'h11, exp_sw: 64'h7FFF_FFFF_FFFF_FCA5, exp_ovf: 1'b1, exp_bytes: 26'd3};

    reset = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0;
    ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = 8'h00;
    tick(3);
    check("rst dip_sw", dip_sw, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst flags", 64'({dip_valid, hdr_valid, dl_done, dip_overflow}), 64'h0);
    check("rst hdr", 64'(hdr), 64'h0);
    check("rst dl_index", 64'(dl_index), 64'h0);
    check("rst dl_bytes", 64'(dl_bytes), 64'h0);
    reset = 1'b1;
    tick(2);
    check("no done after reset", 64'(done_cnt), 64'd0);

    // DIP session 1: two in-range writes.
    start_sess(8'd254);
    for (int i = 0; i < 2; i++) apply_vec(i);
    ioctl_download = 1'b0;
    tick(1);
    check("s1 dl_done high", 64'(dl_done), 64'd1);
    tick(1);
    check("s1 dl_done low", 64'(dl_done), 64'd0);
    check("s1 done count", 64'(done_cnt), 64'd1);
    check("s1 dl_index", 64'(dl_index), 64'd254);
    check("s1 dl_bytes", 64'(dl_bytes), 64'd2);
    check("s1 dip_valid", 64'(dip_valid), 64'd1);

    // DIP session 2: bank 7 plus two out-of-range addresses.
    start_sess(8'd254);
    for (int i = 2; i < 5; i++) apply_vec(i);
    end_sess();
    check("s2 dl_bytes", 64'(dl_bytes), 64'd3);
    check("s2 overflow kept", 64'(dip_overflow), 64'd1);

    // DIP session 3: overflow cleared at start; foreign index ignored.
    start_sess(8'd254);
    check("s3 overflow cleared", 64'(dip_overflow), 64'd0);
    check("s3 bytes cleared", 64'(dl_bytes), 64'd0);
    wr_byte(25'd2, 8'h44);
    check("s3 dip_sw", dip_sw, 64'h7FFF_FFFF_FFBB_FCA5);
    ioctl_index = 8'd0;
    wr_byte(25'd3, 8'h99);
    wr_byte(25'd3, 8'h98);
    check("idx switch dip_sw", dip_sw, 64'h7FFF_FFFF_FFBB_FCA5);
    check("idx switch dl_bytes", 64'(dl_bytes), 64'd1);
    ioctl_index = 8'd254;

    // End, then restart while dl_done is high.
    done_ref = done_cnt;
    ioctl_download = 1'b0;
    tick(1);
    check("restart dl_done", 64'(dl_done), 64'd1);
    start_sess(8'd5);
    for (int i = 0; i < 3; i++) wr_byte(25'(i), 8'hC0);
    check("other dl_bytes", 64'(dl_bytes), 64'd3);
    check("other dip_sw", dip_sw, 64'h7FFF_FFFF_FFBB_FCA5);
    end_sess();
    check("restart done count", 64'(done_cnt - done_ref), 64'd2);
    check("other dl_index", 64'(dl_index), 64'd5);

    // Header sessions.
    start_sess(8'd1);
    wr_byte(25'd0, 8'h01);
    wr_byte(25'd1, 8'h02);
    end_sess();
    tick(1);
    check("hdr value", 64'(hdr), 64'h0201);
    check("hdr_valid set", 64'(hdr_valid), 64'd1);
    check("hdr dl_index", 64'(dl_index), 64'd1);
    start_sess(8'd1);
    wr_byte(25'd0, 8'h33);
    end_sess();
    tick(1);
    check("hdr partial value", 64'(hdr), 64'h0233);
    check("hdr_valid cleared", 64'(hdr_valid), 64'd0);

    // Reset in the middle of a DIP session.
    start_sess(8'd254);
    wr_byte(25'd0, 8'h10);
    wr_byte(25'd1, 8'h20);
    wr_byte(25'd2, 8'h30);
    done_ref = done_cnt;
    reset = 1'b0;
    #3;
    check("midrst dip_sw", dip_sw, 64'hFFFF_FFFF_FFFF_FFFF);
    check("midrst dl_bytes", 64'(dl_bytes), 64'd0);
    check("midrst flags", 64'({dip_valid, hdr_valid, dip_overflow}), 64'h0);
    check("midrst hdr", 64'(hdr), 64'h0);
    ioctl_download = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(3);
    check("midrst no done", 64'(done_cnt - done_ref), 64'd0);

    // Download already high at reset release.
    reset = 1'b0;
    ioctl_download = 1'b1;
    ioctl_index = 8'd254;
    tick(1);
    reset = 1'b1;
    tick(1);
    done_ref = done_cnt;
    wr_byte(25'd0, 8'h77);
    check("highrel dip_sw", dip_sw, 64'hFFFF_FFFF_FFFF_FFFF);
    check("highrel dip_valid", 64'(dip_valid), 64'd0);
    check("highrel dl_bytes", 64'(dl_bytes), 64'd0);
    ioctl_download = 1'b0;
    tick(3);
    check("highrel no done", 64'(done_cnt - done_ref), 64'd0);
    start_sess(8'd254);
    wr_byte(25'd0, 8'h77);
    check("after highrel dip_sw", dip_sw, 64'hFFFF_FFFF_FFFF_FF88);
    end_sess();
    check("after highrel done", 64'(done_cnt - done_ref), 64'd1);
    check("after highrel bytes", 64'(dl_bytes), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
